// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU with registered results and iterative unsigned multiply/divide
module alu_seq #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] ALUctrl,
  input  logic [WIDTH-1:0]  ALUop1,
  input  logic [WIDTH-1:0]  ALUop2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  ALUout,
  output logic              EQ,
  output logic              LT,
  output logic              LTU,
  output logic              busy
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [CTRL_W-1:0] OP_ADD   = CTRL_W'(4'h0);
  localparam logic [CTRL_W-1:0] OP_SUB   = CTRL_W'(4'h1);
  localparam logic [CTRL_W-1:0] OP_AND   = CTRL_W'(4'h2);
  localparam logic [CTRL_W-1:0] OP_OR    = CTRL_W'(4'h3);
  localparam logic [CTRL_W-1:0] OP_XOR   = CTRL_W'(4'h4);
  localparam logic [CTRL_W-1:0] OP_SLT   = CTRL_W'(4'h5);
  localparam logic [CTRL_W-1:0] OP_SLTU  = CTRL_W'(4'h6);
  localparam logic [CTRL_W-1:0] OP_SLL   = CTRL_W'(4'h7);
  localparam logic [CTRL_W-1:0] OP_SRL   = CTRL_W'(4'h8);
  localparam logic [CTRL_W-1:0] OP_SRA   = CTRL_W'(4'h9);
  localparam logic [CTRL_W-1:0] OP_MUL   = CTRL_W'(4'hA);
  localparam logic [CTRL_W-1:0] OP_MULHU = CTRL_W'(4'hB);
  localparam logic [CTRL_W-1:0] OP_DIVU  = CTRL_W'(4'hC);
  localparam logic [CTRL_W-1:0] OP_REMU  = CTRL_W'(4'hD);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t             state;
  logic [SHW-1:0]     cnt;
  logic [CTRL_W-1:0]  op_q;
  logic [WIDTH-1:0]   opr;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic               eq_q;
  logic               lt_q;
  logic               ltu_q;

  logic               accept;
  logic               is_slow_in;
  logic               is_mul_in;
  logic               op_is_mul;
  logic               eq_in;
  logic               lt_in;
  logic               ltu_in;
  logic [SHW-1:0]     shamt;
  logic [WIDTH-1:0]   fast_res;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_hi_n;
  logic [WIDTH-1:0]   mul_lo_n;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   div_hi_n;
  logic [WIDTH-1:0]   div_lo_n;
  logic [WIDTH-1:0]   slow_res;

  assign in_ready = rst_n & ((state == S_IDLE) | ((state == S_DONE) & out_ready));
  assign accept   = in_valid & in_ready;

  assign is_mul_in  = (ALUctrl == OP_MUL) || (ALUctrl == OP_MULHU);
  assign is_slow_in = is_mul_in || (ALUctrl == OP_DIVU) || (ALUctrl == OP_REMU);
  assign op_is_mul  = (op_q == OP_MUL) || (op_q == OP_MULHU);

  assign eq_in  = (ALUop1 == ALUop2);
  assign lt_in  = ($signed(ALUop1) < $signed(ALUop2));
  assign ltu_in = (ALUop1 < ALUop2);
  assign shamt  = ALUop2[SHW-1:0];

  always_comb begin
    fast_res = '0;
    case (ALUctrl)
      OP_ADD:  fast_res = ALUop1 + ALUop2;
      OP_SUB:  fast_res = ALUop1 - ALUop2;
      OP_AND:  fast_res = ALUop1 & ALUop2;
      OP_OR:   fast_res = ALUop1 | ALUop2;
      OP_XOR:  fast_res = ALUop1 ^ ALUop2;
      OP_SLT:  fast_res = WIDTH'(lt_in);
      OP_SLTU: fast_res = WIDTH'(ltu_in);
      OP_SLL:  fast_res = ALUop1 << shamt;
      OP_SRL:  fast_res = ALUop1 >> shamt;
      OP_SRA:  fast_res = WIDTH'($signed(ALUop1) >>> shamt);
      default: fast_res = '0;
    endcase
  end

  // Multiply: {acc_hi, acc_lo} starts as {0, B}; add A into the high half on a set LSB, then shift right.
  assign mul_sum  = {1'b0, acc_hi} + ({1'b0, opr} & {(WIDTH + 1){acc_lo[0]}});
  assign mul_hi_n = mul_sum[WIDTH:1];
  assign mul_lo_n = {mul_sum[0], acc_lo[WIDTH-1:1]};

  // Restoring divide: acc_hi is the partial remainder, acc_lo shifts dividend bits out and quotient bits in.
  // A zero divisor naturally yields an all-ones quotient and the dividend as remainder.
  assign div_sh   = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, opr};
  assign div_ge   = ~div_diff[WIDTH];
  assign div_hi_n = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
  assign div_lo_n = {acc_lo[WIDTH-2:0], div_ge};

  always_comb begin
    slow_res = div_hi_n;
    case (op_q)
      OP_MUL:   slow_res = mul_lo_n;
      OP_MULHU: slow_res = mul_hi_n;
      OP_DIVU:  slow_res = div_lo_n;
      default:  slow_res = div_hi_n;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      ALUout    <= '0;
      EQ        <= 1'b0;
      LT        <= 1'b0;
      LTU       <= 1'b0;
      cnt       <= '0;
      op_q      <= '0;
      opr       <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      eq_q      <= 1'b0;
      lt_q      <= 1'b0;
      ltu_q     <= 1'b0;
    end else if (accept) begin
      if (is_slow_in) begin
        state     <= S_BUSY;
        busy      <= 1'b1;
        out_valid <= 1'b0;
        cnt       <= SHW'(WIDTH - 1);
        op_q      <= ALUctrl;
        opr       <= is_mul_in ? ALUop1 : ALUop2;
        acc_hi    <= '0;
        acc_lo    <= is_mul_in ? ALUop2 : ALUop1;
        eq_q      <= eq_in;
        lt_q      <= lt_in;
        ltu_q     <= ltu_in;
      end else begin
        state     <= S_DONE;
        busy      <= 1'b0;
        out_valid <= 1'b1;
        ALUout    <= fast_res;
        EQ        <= eq_in;
        LT        <= lt_in;
        LTU       <= ltu_in;
      end
    end else begin
      case (state)
        S_BUSY: begin
          if (op_is_mul) begin
            acc_hi <= mul_hi_n;
            acc_lo <= mul_lo_n;
          end else begin
            acc_hi <= div_hi_n;
            acc_lo <= div_lo_n;
          end
          if (cnt == '0) begin
            // Flags were captured at accept and are published together with the result.
            state     <= S_DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            ALUout    <= slow_res;
            EQ        <= eq_q;
            LT        <= lt_q;
            LTU       <= ltu_q;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - randomized self-checking bench for alu_seq against an arithmetic reference model
`timescale 1ns/1ps
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ALUctrl;
  logic [31:0] ALUop1;
  logic [31:0] ALUop2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUout;
  logic        EQ, LT, LTU, busy;

  int n_checks = 0;
  int n_fail   = 0;

  alu_seq #(.WIDTH(32), .CTRL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ALUctrl(ALUctrl), .ALUop1(ALUop1), .ALUop2(ALUop2),
    .out_valid(out_valid), .out_ready(out_ready), .ALUout(ALUout),
    .EQ(EQ), .LT(LT), .LTU(LTU), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0]        p;
    logic signed [31:0] sa;
    int                 sh;
    p  = {32'b0, a} * {32'b0, b};
    sa = a;
    sh = int'(b & 32'd31);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:    return (a < b) ? 32'd1 : 32'd0;
      4'd7:    return a << sh;
      4'd8:    return a >> sh;
      4'd9:    return 32'(sa >>> sh);
      4'd10:   return p[31:0];
      4'd11:   return p[63:32];
      4'd12:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd13:   return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [2:0] model_flags(input logic [31:0] a, input logic [31:0] b);
    return {a == b, $signed(a) < $signed(b), a < b};
  endfunction

  function automatic bit is_slow(input logic [3:0] op);
    return op >= 4'd10 && op <= 4'd13;
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'($urandom_range(0, 20));
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Issues one op with out_ready high, scrambles the inputs right after accept, returns what the DUT produced.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic [2:0] flg, output int lat, output int bcyc);
    int guard;
    @(negedge clk);
    ALUctrl = op; ALUop1 = a; ALUop2 = b; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    ALUctrl = 4'($urandom); ALUop1 = $urandom; ALUop2 = $urandom;
    lat = 0; bcyc = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy) bcyc++;
    end while (!out_valid && lat < 100);
    res = ALUout;
    flg = {EQ, LT, LTU};
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    ALUctrl = '0; ALUop1 = '0; ALUop2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({out_valid, busy, EQ, LT, LTU} !== 5'b0 || ALUout !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ov=%b busy=%b out=%h flags=%b%b%b, want all 0", out_valid, busy, ALUout, EQ, LT, LTU);
    end
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b want 0", in_ready);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_fast();
    logic [31:0] r;
    logic [2:0]  f;
    int          lat, bc;
    logic [3:0]  op;
    logic [31:0] a, b;
    run_op(4'd0, 32'hFFFF_FFFF, 32'd1, r, f, lat, bc);
    n_checks++;
    if (r !== 32'd0 || f !== 3'b010 || lat !== 1) begin
      n_fail++;
      $display("FAIL add_wrap: got out=%h flags=%b lat=%0d, want out=0 flags=010 lat=1", r, f, lat);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL add_single_valid: out_valid=%b on second cycle, want 0", out_valid);
    end
    run_op(4'd5, 32'hFFFF_FFFE, 32'd1, r, f, lat, bc);
    n_checks++;
    if (r !== 32'd1) begin n_fail++; $display("FAIL slt_directed: got %h want 1", r); end
    run_op(4'd6, 32'hFFFF_FFFE, 32'd1, r, f, lat, bc);
    n_checks++;
    if (r !== 32'd0) begin n_fail++; $display("FAIL sltu_directed: got %h want 0", r); end
    run_op(4'd9, 32'h8000_0000, 32'h24, r, f, lat, bc);
    n_checks++;
    if (r !== 32'hF800_0000) begin n_fail++; $display("FAIL sra_directed: got %h want f8000000", r); end
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 11));
      if (op >= 4'd10) op = op + 4'd4;
      a = rnd_operand(); b = rnd_operand();
      run_op(op, a, b, r, f, lat, bc);
      n_checks++;
      if (r !== model_res(op, a, b) || f !== model_flags(a, b) || lat !== 1) begin
        n_fail++;
        $display("FAIL fast_rand op=%0d a=%h b=%h: got out=%h flags=%b lat=%0d, want out=%h flags=%b lat=1",
                 op, a, b, r, f, lat, model_res(op, a, b), model_flags(a, b));
      end
    end
  endtask

  task automatic test_slow();
    logic [31:0] r;
    logic [2:0]  f;
    int          lat, bc;
    logic [3:0]  op;
    logic [31:0] a, b;
    run_op(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, f, lat, bc);
    n_checks++;
    if (r !== 32'd1 || lat !== 33 || bc !== 32 || f !== 3'b100) begin
      n_fail++;
      $display("FAIL mul_ones: got out=%h lat=%0d busy=%0d flags=%b, want 1/33/32/100", r, lat, bc, f);
    end
    run_op(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, f, lat, bc);
    n_checks++;
    if (r !== 32'hFFFF_FFFE || lat !== 33 || bc !== 32) begin
      n_fail++;
      $display("FAIL mulhu_ones: got out=%h lat=%0d busy=%0d, want fffffffe/33/32", r, lat, bc);
    end
    run_op(4'd12, 32'd100, 32'd7, r, f, lat, bc);
    n_checks++;
    if (r !== 32'd14) begin n_fail++; $display("FAIL divu_100_7: got %h want 14", r); end
    run_op(4'd13, 32'd100, 32'd7, r, f, lat, bc);
    n_checks++;
    if (r !== 32'd2) begin n_fail++; $display("FAIL remu_100_7: got %h want 2", r); end
    run_op(4'd12, 32'd5, 32'd0, r, f, lat, bc);
    n_checks++;
    if (r !== 32'hFFFF_FFFF || lat !== 33) begin
      n_fail++;
      $display("FAIL divu_by_zero: got out=%h lat=%0d want ffffffff/33", r, lat);
    end
    run_op(4'd13, 32'd5, 32'd0, r, f, lat, bc);
    n_checks++;
    if (r !== 32'd5 || lat !== 33) begin
      n_fail++;
      $display("FAIL remu_by_zero: got out=%h lat=%0d want 5/33", r, lat);
    end
    for (int i = 0; i < 16; i++) begin
      op = 4'($urandom_range(10, 13));
      a = rnd_operand(); b = rnd_operand();
      run_op(op, a, b, r, f, lat, bc);
      n_checks++;
      if (r !== model_res(op, a, b) || f !== model_flags(a, b) || lat !== 33 || bc !== 32) begin
        n_fail++;
        $display("FAIL slow_rand op=%0d a=%h b=%h: got out=%h flags=%b lat=%0d busy=%0d, want out=%h flags=%b lat=33 busy=32",
                 op, a, b, r, f, lat, bc, model_res(op, a, b), model_flags(a, b));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] r0;
    logic [2:0]  f0;
    bit          stable, rdy_low;
    @(negedge clk);
    out_ready = 1'b0;
    ALUctrl = 4'd4; ALUop1 = 32'h1234_5678; ALUop2 = 32'h0F0F_0F0F; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || ALUout !== model_res(4'd4, 32'h1234_5678, 32'h0F0F_0F0F)) begin
      n_fail++;
      $display("FAIL bp_first: got ov=%b out=%h want ov=1 out=%h", out_valid, ALUout,
               model_res(4'd4, 32'h1234_5678, 32'h0F0F_0F0F));
    end
    r0 = ALUout; f0 = {EQ, LT, LTU};
    ALUctrl = 4'd0; ALUop1 = 32'd2; ALUop2 = 32'd3; in_valid = 1'b1;
    stable = 1'b1; rdy_low = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (in_ready !== 1'b0) rdy_low = 1'b0;
      @(negedge clk);
      if (ALUout !== r0 || {EQ, LT, LTU} !== f0 || out_valid !== 1'b1) stable = 1'b0;
    end
    n_checks++;
    if (!stable) begin n_fail++; $display("FAIL bp_hold: got out=%h ov=%b want out=%h ov=1", ALUout, out_valid, r0); end
    n_checks++;
    if (!rdy_low) begin n_fail++; $display("FAIL bp_in_ready: got 1 while stalled want 0"); end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ALUout !== 32'd5 || out_valid !== 1'b1 || {EQ, LT, LTU} !== 3'b011) begin
      n_fail++;
      $display("FAIL bp_same_cycle_add: got out=%h ov=%b flags=%b%b%b want 5/1/011", ALUout, out_valid, EQ, LT, LTU);
    end
  endtask

  task automatic test_reset_mid_div();
    bit seen;
    @(negedge clk);
    ALUctrl = 4'd12; ALUop1 = 32'd1000; ALUop2 = 32'd3; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({out_valid, busy, EQ, LT, LTU} !== 5'b0 || ALUout !== 32'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_div: got ov=%b busy=%b out=%h flags=%b%b%b rdy=%b want zeros and rdy=1",
               out_valid, busy, ALUout, EQ, LT, LTU, in_ready);
    end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid || busy) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin n_fail++; $display("FAIL reset_no_stale: got stale out_valid/busy want none"); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  op, pop;
    logic [31:0] a, b, pa, pb;
    logic [31:0] exp1, exp2;
    int          k1, k2;
    bit          dropped;
    out_ready = 1'b1;
    @(negedge clk);
    op = 4'($urandom_range(0, 9)); a = rnd_operand(); b = rnd_operand();
    ALUctrl = op; ALUop1 = a; ALUop2 = b; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      pop = op; pa = a; pb = b;
      if (i < 19) begin
        op = 4'($urandom_range(0, 9)); a = rnd_operand(); b = rnd_operand();
        ALUctrl = op; ALUop1 = a; ALUop2 = b;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || ALUout !== model_res(pop, pa, pb) || in_ready !== (i < 19 ? 1'b1 : 1'b1)) begin
        n_fail++;
        $display("FAIL b2b_fast[%0d] op=%0d: got ov=%b out=%h want ov=1 out=%h", i, pop, out_valid, ALUout,
                 model_res(pop, pa, pb));
      end
    end
    @(negedge clk);
    exp1 = model_res(4'd12, 32'd1000, 32'd9);
    exp2 = model_res(4'd11, 32'hDEAD_BEEF, 32'h1234_5678);
    ALUctrl = 4'd12; ALUop1 = 32'd1000; ALUop2 = 32'd9; in_valid = 1'b1;
    @(posedge clk);
    #1;
    ALUctrl = 4'd11; ALUop1 = 32'hDEAD_BEEF; ALUop2 = 32'h1234_5678;
    k1 = 0; k2 = 0; dropped = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (out_valid && k1 == 0) begin
        k1 = k;
        n_checks++;
        if (ALUout !== exp1) begin n_fail++; $display("FAIL b2b_slow_first: got %h want %h", ALUout, exp1); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dropped = 1'b1;
      end else if (out_valid && dropped && k2 == 0) begin
        k2 = k;
        n_checks++;
        if (ALUout !== exp2) begin n_fail++; $display("FAIL b2b_slow_second: got %h want %h", ALUout, exp2); end
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (k1 !== 33 || k2 !== 66) begin
      n_fail++;
      $display("FAIL b2b_slow_timing: got results at cycles %0d and %0d want 33 and 66", k1, k2);
    end
  endtask

  initial begin
    test_reset();
    test_fast();
    test_slow();
    test_backpressure();
    test_reset_mid_div();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
